mcb_port_responder: RTL and testbench
=====================================

Name: mcb_port_responder

Overview:
- Behavioural and synthesizable stand-in for the responder end of the MCB user port (cmd/wr/rd FIFO protocol) that mem_manager drives as initiator.
- Serves commands from on-chip block RAM so the system can run and be verified without the LPDDR device or its calibration.
- Port-compatible with c3_p0_* signals: single clock domain, cmd/wr/rd clocks tied together.

Parameters:
- ADDR_WORDS_LOG2, 12, log2 of backing RAM depth in 32-bit words.
- CMD_DEPTH, 4, command FIFO depth (power of 2).
- DATA_DEPTH, 64, write and read data FIFO depth (power of 2, ≤64).
- CALIB_DELAY, 16, cycles after reset release before calib_done rises.

Ports:
- clk in 1: the single clock. All port activity is sampled on its rising edge.
- rst_n in 1: reset, asynchronous, active-low.
- calib_done out 1: responder ready.
- cmd_en in 1; cmd_instr in 3; cmd_bl in 6 (words minus 1); cmd_byte_addr in 30.
- cmd_empty out 1; cmd_full out 1.
- wr_en in 1; wr_mask in 4 (1 = byte not written); wr_data in 32.
- wr_full out 1; wr_empty out 1; wr_count out 7; wr_underrun out 1; wr_error out 1.
- rd_en in 1; rd_data out 32.
- rd_full out 1; rd_empty out 1; rd_count out 7; rd_overflow out 1; rd_error out 1.

Behaviour:
- Reset values: calib_done 0; cmd_empty, wr_empty, rd_empty 1; cmd_full 1; all other outputs 0.
- Reset flushes all FIFOs, aborts any burst and restarts the calibration counter. RAM contents are retained.
- Calibration: calib_done rises exactly CALIB_DELAY cycles after rst_n deasserts. cmd_full is held 1 until then, so cmd_en is ignored before calib_done.
- Command accept: on cmd_en && !cmd_full, push {instr, bl, addr}. cmd_empty falls the next cycle.
- Word address = cmd_byte_addr[ADDR_WORDS_LOG2+1:2]. Higher bits are ignored, giving alias/wrap. Each burst word increments the address modulo RAM depth.
- Write FIFO: push on wr_en && !wr_full. wr_en while full: data dropped, wr_error set sticky until reset.
- Read FIFO is first-word-fall-through: rd_data is valid whenever !rd_empty; pop on rd_en && !rd_empty. rd_en while empty: no pop, rd_error set sticky.
- Simultaneous push and pop on the same FIFO in one cycle leaves its count unchanged.
- Engine states: CALIB, IDLE, WRITE, READ.
- CALIB → IDLE when calib_done rises.
- IDLE: when the cmd FIFO is non-empty, pop the command and decode it:
  - instr 0 or 2 → WRITE.
  - instr 1 or 3 → READ, entered only when free read-FIFO space ≥ bl+1; otherwise stay in IDLE holding the command.
  - any other instr (refresh etc.) is consumed as a one-cycle no-op.
- WRITE: each cycle the write FIFO is non-empty, pop one word and write the RAM with the byte mask applied. If it is empty, stall and pulse wr_underrun high for that cycle. After bl+1 words → IDLE.
- READ: issue one RAM read per cycle for bl+1 cycles. RAM latency is 1 cycle; each word is pushed into the read FIFO on the following cycle. Enter IDLE after the final push.
- Read-after-write coherency: commands execute strictly in order and a write completes in RAM before the next command is popped, so a following read returns the new data.
- rd_overflow asserts only if a push is attempted while the read FIFO is full. The space check prevents this; it is retained as an assertion-style flag, sticky until reset.

Optional Feature:
- MCB_RESP_BACKPRESSURE_EN defined: a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle. When its bit 0 is 1, IDLE does not pop a command and WRITE/READ do not advance that cycle. This injects random latency to stress the initiator's pause/timeout logic.
- Undefined: no stalls; minimum single-word read latency from cmd_en to !rd_empty is 4 cycles.

Decomposition:
- Package mcb_resp_pkg holds the instr codes (WRITE=0, READ=1, WRITE_AP=2, READ_AP=3, REFRESH=4), engine state encodings and the command record width.
- One sub-module, mcb_resp_fifo: synchronous FWFT FIFO with WIDTH/DEPTH parameters and full/empty/count/error outputs, instantiated three times (cmd, wr, rd).

Test Plan:
- Reset with CALIB_DELAY=16 → calib_done rises on cycle 16, cmd_full=1 until then; cmd_en pulses on cycles 3–10 are ignored and cmd_empty stays 1.
- Write 32'hF0806020 to byte addr 0x20 (bl=0), then read 0x20 → rd_empty falls, rd_data=32'hF0806020, rd_count=1.
- Write 32'h11223344 to 0x40, then masked write 32'hAABBCCDD with mask 4'b0011 → read returns 32'hAABB3344.
- Preload 62 words in the read FIFO and issue a read with bl=3 → engine waits in IDLE until rd_count ≤60; rd_overflow stays 0.
- Fill the write FIFO to 64 then assert wr_en → wr_error=1 sticky, wr_count stays 64. Issue rd_en while empty → rd_error=1.
- Write with bl=1 and only one word queued → wr_underrun pulses each cycle until the 2nd word arrives. Byte addr 0x4000 with ADDR_WORDS_LOG2=12 aliases to 0x0.

Source files
------------

// File: rtl/mcb_resp_pkg.sv
// Shared instruction codes, engine state encoding and command record sizing
// for the MCB user-port responder.
package mcb_resp_pkg;

  localparam logic [2:0] INSTR_WRITE    = 3'd0;
  localparam logic [2:0] INSTR_READ     = 3'd1;
  localparam logic [2:0] INSTR_WRITE_AP = 3'd2;
  localparam logic [2:0] INSTR_READ_AP  = 3'd3;
  localparam logic [2:0] INSTR_REFRESH  = 3'd4;

  typedef enum logic [1:0] {
    ST_CALIB = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } eng_state_e;

  // Command record is {instr(3), bl(6), word address}.
  localparam int CMD_HDR_W = 9;

  function automatic int cmd_rec_w(input int addr_words_log2);
    return CMD_HDR_W + addr_words_log2;
  endfunction

endpackage

// File: rtl/mcb_resp_fifo.sv
// Synchronous first-word-fall-through FIFO with sticky push-while-full and
// pop-while-empty flags; DEPTH must be a power of 2.
module mcb_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_push_err,
  output logic                   o_pop_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      o_push_err <= 1'b0;
      o_pop_err  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (i_push && o_full)  o_push_err <= 1'b1;
      if (i_pop  && o_empty) o_pop_err  <= 1'b1;
    end
  end

  // Storage is not reset: pointers define validity, so reset is a flush.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

endmodule

// File: rtl/mcb_port_responder.sv
// Block-RAM backed responder for the MCB user port (cmd/wr/rd FIFOs, one clock).
// Define MCB_RESP_BACKPRESSURE_EN to inject LFSR-driven random engine stalls.
module mcb_port_responder
  import mcb_resp_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 12,
  parameter int CMD_DEPTH       = 4,
  parameter int DATA_DEPTH      = 64,
  parameter int CALIB_DELAY     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        calib_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [29:0] cmd_byte_addr,
  output logic        cmd_empty,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [3:0]  wr_mask,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error
);
  localparam int AW  = ADDR_WORDS_LOG2;
  localparam int CW  = cmd_rec_w(AW);
  localparam int DCW = $clog2(DATA_DEPTH) + 1;
  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int KW  = $clog2(CALIB_DELAY + 1);

  eng_state_e       r_state, w_next;
  logic             r_calib;
  logic [KW-1:0]    r_cal_cnt;
  logic [AW-1:0]    r_addr;
  logic [5:0]       r_left;
  logic             r_rd_last, r_push;
  logic [31:0]      r_rdata;
  logic [31:0]      r_mem [2**AW];

  logic [CW-1:0]    w_cmd_dout;
  logic [2:0]       w_cmd_instr;
  logic [5:0]       w_cmd_bl;
  logic [AW-1:0]    w_cmd_addr;
  logic             w_cmd_full, w_cmd_pop;
  logic [CCW-1:0]   w_cmd_cnt_unused;
  logic [1:0]       w_cmd_err_unused;
  logic [29-AW:0]   w_addr_unused;
  logic [35:0]      w_wr_dout;
  logic             w_wr_pop, w_wr_udf_unused;
  logic [DCW-1:0]   w_wr_cnt, w_rd_cnt;
  logic [31:0]      w_rd_dout;
  logic [7:0]       w_rd_free;
  logic             w_rd_issue, w_load, w_underrun, w_stall;

  assign calib_done    = r_calib;
  assign cmd_full      = !r_calib || w_cmd_full;
  assign w_addr_unused = {cmd_byte_addr[29:AW+2], cmd_byte_addr[1:0]};
  assign w_cmd_instr   = w_cmd_dout[CW-1 -: 3];
  assign w_cmd_bl      = w_cmd_dout[AW +: 6];
  assign w_cmd_addr    = w_cmd_dout[AW-1:0];
  assign wr_count      = 7'(w_wr_cnt);
  assign rd_count      = 7'(w_rd_cnt);
  assign rd_data       = rd_empty ? 32'd0 : w_rd_dout;
  assign wr_underrun   = w_underrun;
  assign w_rd_free     = 8'(DATA_DEPTH) - 8'(w_rd_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cal_cnt <= '0;
      r_calib   <= 1'b0;
    end else if (!r_calib) begin
      r_cal_cnt <= r_cal_cnt + KW'(1);
      r_calib   <= (r_cal_cnt == KW'(CALIB_DELAY - 1));
    end
  end

  mcb_resp_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_push(cmd_en && r_calib),
    .i_din({cmd_instr, cmd_bl, cmd_byte_addr[AW+1:2]}),
    .i_pop(w_cmd_pop), .o_dout(w_cmd_dout),
    .o_full(w_cmd_full), .o_empty(cmd_empty), .o_count(w_cmd_cnt_unused),
    .o_push_err(w_cmd_err_unused[0]), .o_pop_err(w_cmd_err_unused[1])
  );

  mcb_resp_fifo #(.WIDTH(36), .DEPTH(DATA_DEPTH)) u_wr_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_push(wr_en), .i_din({wr_mask, wr_data}),
    .i_pop(w_wr_pop), .o_dout(w_wr_dout),
    .o_full(wr_full), .o_empty(wr_empty), .o_count(w_wr_cnt),
    .o_push_err(wr_error), .o_pop_err(w_wr_udf_unused)
  );

  mcb_resp_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH)) u_rd_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_push(r_push), .i_din(r_rdata),
    .i_pop(rd_en), .o_dout(w_rd_dout),
    .o_full(rd_full), .o_empty(rd_empty), .o_count(w_rd_cnt),
    .o_push_err(rd_overflow), .o_pop_err(rd_error)
  );

`ifdef MCB_RESP_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_CALIB;
    else        r_state <= w_next;
  end

  // Reads wait in IDLE with the command left at the FIFO head until the
  // whole burst fits, so the read FIFO can never be pushed while full.
  always_comb begin
    w_next     = r_state;
    w_cmd_pop  = 1'b0;
    w_wr_pop   = 1'b0;
    w_rd_issue = 1'b0;
    w_load     = 1'b0;
    w_underrun = 1'b0;
    case (r_state)
      ST_CALIB: if (r_calib) w_next = ST_IDLE;
      ST_IDLE: begin
        if (!cmd_empty && !w_stall) begin
          case (w_cmd_instr)
            INSTR_WRITE, INSTR_WRITE_AP: begin
              w_cmd_pop = 1'b1;
              w_load    = 1'b1;
              w_next    = ST_WRITE;
            end
            INSTR_READ, INSTR_READ_AP: begin
              if (w_rd_free >= ({2'b00, w_cmd_bl} + 8'd1)) begin
                w_cmd_pop = 1'b1;
                w_load    = 1'b1;
                w_next    = ST_READ;
              end
            end
            INSTR_REFRESH: w_cmd_pop = 1'b1;
            default:       w_cmd_pop = 1'b1;
          endcase
        end
      end
      ST_WRITE: begin
        if (!w_stall) begin
          if (wr_empty) begin
            w_underrun = 1'b1;
          end else begin
            w_wr_pop = 1'b1;
            if (r_left == 6'd0) w_next = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        if (r_rd_last)     w_next     = ST_IDLE;
        else if (!w_stall) w_rd_issue = 1'b1;
      end
      default: w_next = ST_CALIB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_left    <= '0;
      r_rd_last <= 1'b0;
      r_push    <= 1'b0;
    end else begin
      r_push <= w_rd_issue;
      if (w_load) begin
        r_addr    <= w_cmd_addr;
        r_left    <= w_cmd_bl;
        r_rd_last <= 1'b0;
      end else if (w_wr_pop || w_rd_issue) begin
        r_addr <= r_addr + AW'(1);
        r_left <= r_left - 6'd1;
        if (w_rd_issue && r_left == 6'd0) r_rd_last <= 1'b1;
      end
    end
  end

  // Backing RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_wr_pop) begin
      for (int b = 0; b < 4; b++) begin
        if (!w_wr_dout[32+b]) r_mem[r_addr][8*b +: 8] <= w_wr_dout[8*b +: 8];
      end
    end
    if (w_rd_issue) r_rdata <= r_mem[r_addr];
  end

endmodule

// File: tb/tb_mcb_port_responder.sv
// Scenario bench for mcb_port_responder: expected read words are queued when
// read commands are issued and compared as the read FIFO delivers them.
module tb_mcb_port_responder;
  import mcb_resp_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        calib_done;
  logic        cmd_en = 1'b0;
  logic [2:0]  cmd_instr = 3'd0;
  logic [5:0]  cmd_bl = 6'd0;
  logic [29:0] cmd_byte_addr = 30'd0;
  logic        cmd_empty, cmd_full;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_mask = 4'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_full, wr_empty, wr_underrun, wr_error;
  logic [6:0]  wr_count, rd_count;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_full, rd_empty, rd_overflow, rd_error;

  int          total = 0, bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mcb_port_responder #(
    .ADDR_WORDS_LOG2(12), .CMD_DEPTH(4), .DATA_DEPTH(64), .CALIB_DELAY(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_empty(cmd_empty), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .wr_full(wr_full), .wr_empty(wr_empty), .wr_count(wr_count),
    .wr_underrun(wr_underrun), .wr_error(wr_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_count(rd_count), .rd_overflow(rd_overflow), .rd_error(rd_error)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
    cmd_en = 1'b1; cmd_instr = instr; cmd_bl = bl; cmd_byte_addr = addr;
    tick;
    cmd_en = 1'b0;
  endtask

  task automatic wr_push(input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; wr_data = d; wr_mask = m;
    tick;
    wr_en = 1'b0;
  endtask

  // Waits (bounded) for a read word, captures it and pops it.
  task automatic rd_pop(output logic [31:0] d, output bit ok);
    int n = 0;
    while (rd_empty && n < 200) begin tick; n++; end
    ok = !rd_empty;
    d  = rd_data;
    if (ok) begin rd_en = 1'b1; tick; rd_en = 1'b0; end
  endtask

  task automatic test_reset;
    logic [10:0] flags;
    tick; tick;
    flags = {calib_done, cmd_empty, cmd_full, wr_full, wr_empty, wr_underrun,
             wr_error, rd_full, rd_empty, rd_overflow, rd_error};
    total++;
    if (flags !== 11'b011_0100_0100) begin
      bad++; $display("FAIL reset_flags: got %b want %b", flags, 11'b011_0100_0100);
    end
    total++;
    if (wr_count !== 7'd0 || rd_count !== 7'd0 || rd_data !== 32'd0) begin
      bad++; $display("FAIL reset_counts: wr_count=%0d rd_count=%0d rd_data=%h want 0", wr_count, rd_count, rd_data);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cmd_en = (k >= 3 && k <= 10); cmd_instr = INSTR_READ; cmd_bl = 6'd0; cmd_byte_addr = 30'h20;
      tick;
      total++;
      if (calib_done !== (k >= 16) || cmd_full !== (k < 16) || cmd_empty !== 1'b1) begin
        bad++;
        $display("FAIL calib_cycle%0d: calib_done=%b cmd_full=%b cmd_empty=%b want %b %b 1",
                 k, calib_done, cmd_full, cmd_empty, k >= 16, k < 16);
      end
    end
    cmd_en = 1'b0;
  endtask

  task automatic test_write_read;
    logic [31:0] d; bit ok;
    wr_push(32'hF0806020, 4'h0);
    send_cmd(INSTR_WRITE, 6'd0, 30'h20);
    repeat (4) tick;
    send_cmd(INSTR_READ, 6'd0, 30'h20);
    exp_q.push_back(32'hF0806020);
    tick; tick;
    total++;
    if (rd_empty !== 1'b1) begin bad++; $display("FAIL rd_latency_early: rd_empty=%b want 1", rd_empty); end
    tick;
    total++;
    if (rd_empty !== 1'b0 || rd_count !== 7'd1 || rd_data !== 32'hF0806020) begin
      bad++; $display("FAIL rd_latency4: rd_empty=%b rd_count=%0d rd_data=%h want 0 1 f0806020", rd_empty, rd_count, rd_data);
    end
    rd_pop(d, ok);
    total++;
    if (!ok || d !== exp_q[0]) begin bad++; $display("FAIL write_read: got %h ok=%0d want %h", d, ok, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_mask;
    logic [31:0] d, e; bit ok;
    wr_push(32'h11223344, 4'b0000);
    wr_push(32'hAABBCCDD, 4'b0011);
    send_cmd(INSTR_WRITE, 6'd0, 30'h40);
    send_cmd(INSTR_WRITE_AP, 6'd0, 30'h40);
    repeat (6) tick;
    send_cmd(INSTR_READ_AP, 6'd0, 30'h40);
    exp_q.push_back(32'hAABB3344);
    rd_pop(d, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) begin bad++; $display("FAIL masked_write: got %h ok=%0d want %h", d, ok, e); end
    total++;
    if (rd_empty !== 1'b1 || rd_count !== 7'd0) begin
      bad++; $display("FAIL mask_drain: rd_empty=%b rd_count=%0d want 1 0", rd_empty, rd_count);
    end
  endtask

  task automatic test_rd_space;
    logic [31:0] d, e; bit ok; int n;
    for (int i = 0; i < 62; i++) wr_push(32'hC0DE0000 | i, 4'h0);
    send_cmd(INSTR_WRITE, 6'd61, 30'h100);
    send_cmd(INSTR_READ, 6'd61, 30'h100);
    for (int i = 0; i < 62; i++) exp_q.push_back(32'hC0DE0000 | i);
    n = 0;
    while (rd_count !== 7'd62 && n < 400) begin tick; n++; end
    total++;
    if (rd_count !== 7'd62) begin bad++; $display("FAIL preload62: rd_count=%0d want 62", rd_count); end
    send_cmd(INSTR_READ, 6'd3, 30'h100);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0DE0000 | i);
    repeat (10) tick;
    total++;
    if (rd_count !== 7'd62 || cmd_empty !== 1'b0) begin
      bad++; $display("FAIL space_hold62: rd_count=%0d cmd_empty=%b want 62 0", rd_count, cmd_empty);
    end
    rd_pop(d, ok); e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) begin bad++; $display("FAIL space_pop0: got %h want %h", d, e); end
    repeat (5) tick;
    total++;
    if (rd_count !== 7'd61 || cmd_empty !== 1'b0) begin
      bad++; $display("FAIL space_hold61: rd_count=%0d cmd_empty=%b want 61 0", rd_count, cmd_empty);
    end
    rd_pop(d, ok); e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) begin bad++; $display("FAIL space_pop1: got %h want %h", d, e); end
    n = 0;
    while (rd_count !== 7'd64 && n < 50) begin tick; n++; end
    total++;
    if (rd_count !== 7'd64 || rd_full !== 1'b1 || rd_overflow !== 1'b0) begin
      bad++; $display("FAIL space_release: rd_count=%0d rd_full=%b rd_overflow=%b want 64 1 0", rd_count, rd_full, rd_overflow);
    end
    for (int i = 0; i < 64; i++) begin
      rd_pop(d, ok); e = exp_q.pop_front();
      total++;
      if (!ok || d !== e) begin bad++; $display("FAIL space_drain%0d: got %h ok=%0d want %h", i, d, ok, e); end
    end
    total++;
    if (rd_overflow !== 1'b0) begin bad++; $display("FAIL rd_overflow: got %b want 0", rd_overflow); end
  endtask

  task automatic test_wr_full;
    logic [31:0] d, e; bit ok; int n;
    for (int i = 0; i < 64; i++) wr_push(32'hBEEF0000 | i, 4'h0);
    total++;
    if (wr_count !== 7'd64 || wr_full !== 1'b1 || wr_error !== 1'b0) begin
      bad++; $display("FAIL wr_fill: wr_count=%0d wr_full=%b wr_error=%b want 64 1 0", wr_count, wr_full, wr_error);
    end
    wr_push(32'hDEADDEAD, 4'h0);
    total++;
    if (wr_error !== 1'b1 || wr_count !== 7'd64) begin
      bad++; $display("FAIL wr_overfill: wr_error=%b wr_count=%0d want 1 64", wr_error, wr_count);
    end
    rd_en = 1'b1; tick; rd_en = 1'b0;
    total++;
    if (rd_error !== 1'b1 || rd_count !== 7'd0) begin
      bad++; $display("FAIL rd_underflow: rd_error=%b rd_count=%0d want 1 0", rd_error, rd_count);
    end
    repeat (3) tick;
    total++;
    if (wr_error !== 1'b1 || rd_error !== 1'b1) begin
      bad++; $display("FAIL err_sticky: wr_error=%b rd_error=%b want 1 1", wr_error, rd_error);
    end
    send_cmd(INSTR_WRITE, 6'd63, 30'h400);
    n = 0;
    while (!wr_empty && n < 200) begin tick; n++; end
    total++;
    if (wr_empty !== 1'b1) begin bad++; $display("FAIL wr_drain: wr_empty=%b want 1", wr_empty); end
    tick; tick;
    send_cmd(INSTR_REFRESH, 6'd0, 30'h0);
    tick; tick;
    total++;
    if (cmd_empty !== 1'b1 || rd_empty !== 1'b1) begin
      bad++; $display("FAIL refresh_noop: cmd_empty=%b rd_empty=%b want 1 1", cmd_empty, rd_empty);
    end
    send_cmd(INSTR_READ, 6'd1, 30'h400);
    exp_q.push_back(32'hBEEF0000); exp_q.push_back(32'hBEEF0001);
    for (int i = 0; i < 2; i++) begin
      rd_pop(d, ok); e = exp_q.pop_front();
      total++;
      if (!ok || d !== e) begin bad++; $display("FAIL full_burst%0d: got %h ok=%0d want %h", i, d, ok, e); end
    end
  endtask

  task automatic test_underrun_alias;
    logic [31:0] d, e; bit ok;
    wr_push(32'h5A5A0001, 4'h0);
    send_cmd(INSTR_WRITE, 6'd1, 30'h4000);
    tick; tick;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (wr_underrun !== 1'b1) begin bad++; $display("FAIL underrun_pulse%0d: got %b want 1", k, wr_underrun); end
      tick;
    end
    wr_push(32'h5A5A0002, 4'h0);
    total++;
    if (wr_underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear: got %b want 0", wr_underrun); end
    tick; tick;
    total++;
    if (wr_underrun !== 1'b0 || wr_empty !== 1'b1) begin
      bad++; $display("FAIL underrun_done: wr_underrun=%b wr_empty=%b want 0 1", wr_underrun, wr_empty);
    end
    send_cmd(INSTR_READ, 6'd1, 30'h0);
    exp_q.push_back(32'h5A5A0001); exp_q.push_back(32'h5A5A0002);
    for (int i = 0; i < 2; i++) begin
      rd_pop(d, ok); e = exp_q.pop_front();
      total++;
      if (!ok || d !== e) begin bad++; $display("FAIL alias_read%0d: got %h ok=%0d want %h", i, d, ok, e); end
    end
  endtask

  task automatic test_reset_flush;
    logic [31:0] d, e; bit ok;
    wr_push(32'h01234567, 4'h0);
    wr_push(32'h89ABCDEF, 4'h0);
    rst_n = 1'b0;
    #1;
    total++;
    if (wr_count !== 7'd0 || wr_empty !== 1'b1 || wr_error !== 1'b0 || rd_error !== 1'b0 ||
        calib_done !== 1'b0 || cmd_full !== 1'b1) begin
      bad++;
      $display("FAIL async_flush: wr_count=%0d wr_empty=%b wr_error=%b rd_error=%b calib=%b cmd_full=%b want 0 1 0 0 0 1",
               wr_count, wr_empty, wr_error, rd_error, calib_done, cmd_full);
    end
    tick;
    rst_n = 1'b1;
    repeat (15) tick;
    total++;
    if (calib_done !== 1'b0) begin bad++; $display("FAIL recal_early: calib_done=%b want 0", calib_done); end
    tick;
    total++;
    if (calib_done !== 1'b1) begin bad++; $display("FAIL recal: calib_done=%b want 1", calib_done); end
    tick;
    send_cmd(INSTR_READ, 6'd0, 30'h20);
    exp_q.push_back(32'hF0806020);
    rd_pop(d, ok); e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) begin bad++; $display("FAIL ram_retained: got %h ok=%0d want %h", d, ok, e); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_rd_space();
    test_wr_full();
    test_underrun_alias();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
